// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
//   XLEN          - PC / instruction width
//   RESET_PC      - byte address fetched first after reset
//   fetch_entry_t - queued instruction tagged with its byte PC
//   NOP           - canonical addi x0,x0,0 encoding
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // byte PC -> word index
  function automatic logic [XLEN-1:0] pc_word(input logic [XLEN-1:0] pc);
    return pc >> 2;
  endfunction
endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus bundle: execute redirect, instruction memory port and
// decode handshake.
//   master - fetch controller side
//   slave  - environment side (execute, imem, decode)
interface fetch_controller_if;
  import riscv_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            halted;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, halted
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, halted
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
//   clk, reset   - clock, synchronous active-high reset
//   push, wdata  - enqueue (ignored when full unless popping the same cycle)
//   pop          - dequeue head (ignored when empty)
//   flush        - drop all entries; dominates push
//   head         - head entry, zero when empty
//   full, empty, count - occupancy
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one word read per cycle,
// queues responses tagged with their PC and presents them to decode.
//   clk, reset - clock, synchronous active-high reset
//   bus        - fetch_controller_if.master (redirect, imem, decode, halted)
module fetch_controller
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int              MEM_DEPTH  = 7,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic            inflight, kill, halted_q;
  logic            end_of_prog, pop, push, issue;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            empty, full;
  fetch_entry_t    head;

  assign end_of_prog = pc_word(fetch_pc) >= XLEN'(MEM_DEPTH);
  assign pop         = bus.if_valid && bus.if_ready;
  // Slots already committed next cycle: queued + returning - leaving now.
  assign occ         = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = !reset && !bus.redirect_valid && !end_of_prog &&
                       (occ < (CW+1)'(FIFO_DEPTH));
  // A response landing during a redirect is dropped by the flush, which
  // dominates push inside the queue; kill covers the cycle after.
  assign push        = inflight && !kill;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = reset ? '0 : pc_word(fetch_pc);
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;
  assign bus.halted    = halted_q;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ('{pc: inflight_pc, instr: bus.imem_rdata}),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= bus.redirect_valid;
      if (issue) inflight_pc <= fetch_pc;
      if (bus.redirect_valid)
        fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      else if (issue)
        fetch_pc <= fetch_pc + XLEN'(4);
      halted_q <= !bus.redirect_valid && end_of_prog && empty && !inflight;
    end
  end

  // The issue rule must keep the queue from overflowing.
  always_ff @(posedge clk) begin
    if (!reset && !bus.redirect_valid)
      assert (!(push && full && !pop));
  end
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  import riscv_pkg::*;

  localparam int MEM_DEPTH = 7;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic [XLEN-1:0] sb[$];

  fetch_controller_if bus();

  fetch_controller #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] word_at(input logic [XLEN-1:0] idx);
    if (idx < XLEN'(MEM_DEPTH)) return 32'hC0DE_0000 | idx;
    return NOP;
  endfunction

  // one-cycle-latency instruction memory
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? word_at(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted instruction must be the next expected PC
  always @(negedge clk) begin : mon
    logic [XLEN-1:0] e;
    if (mon_en && !reset && bus.if_valid && bus.if_ready) begin
      if (sb.size() == 0) chk("extra instr pc", bus.if_pc, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("pop pc", bus.if_pc, e);
        chk("pop instr", bus.if_instr, word_at(e >> 2));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int pc = lo; pc <= hi; pc += 4) sb.push_back(XLEN'(pc));
  endtask

  // leaves the bench at the start of cycle 0 after reset release
  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    cyc(); cyc();
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin cyc(); n++; end
    chk("halted", XLEN'(bus.halted), 1);
    chk("sb drained", XLEN'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    // reset state
    cyc(); sample();
    chk("rst if_valid", XLEN'(bus.if_valid), 0);
    chk("rst imem_req", XLEN'(bus.imem_req), 0);
    chk("rst imem_addr", bus.imem_addr, 0);
    chk("rst if_instr", bus.if_instr, 0);
    chk("rst if_pc", bus.if_pc, 0);
    chk("rst halted", XLEN'(bus.halted), 0);

    // streaming with ready high, run to halt
    do_reset();
    bus.if_ready = 1'b1; mon_en = 1'b1;
    push_range(0, 24);
    sample();
    chk("c0 req", XLEN'(bus.imem_req), 1);
    chk("c0 addr", bus.imem_addr, 0);
    chk("c0 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample();
    chk("c1 addr", bus.imem_addr, 1);
    chk("c1 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample();
    chk("c2 valid", XLEN'(bus.if_valid), 1);
    chk("c2 pc", bus.if_pc, 0);
    wait_halt(30);
    chk("halt no req", XLEN'(bus.imem_req), 0);

    // decode stall for 5 cycles from cycle 3
    do_reset();
    bus.if_ready = 1'b1;
    push_range(0, 24);
    cyc(); cyc(); cyc();
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall req", XLEN'(bus.imem_req), 0);
      chk("stall pc", bus.if_pc, 4);
      cyc();
    end
    bus.if_ready = 1'b1;
    wait_halt(30);

    // redirect to 0x10 while word 2 returns
    do_reset();
    bus.if_ready = 1'b1;
    sb.push_back(0); sb.push_back(4);
    push_range(16, 24);
    cyc(); cyc(); cyc();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    cyc();
    bus.redirect_valid = 1'b0;
    sample(); chk("rd N+1 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample(); chk("rd N+2 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample();
    chk("rd N+3 valid", XLEN'(bus.if_valid), 1);
    chk("rd N+3 pc", bus.if_pc, 32'h10);
    wait_halt(30);

    // reset mid-stream with two queued entries
    do_reset();
    bus.if_ready = 1'b1;
    push_range(0, 24);
    cyc(); cyc(); cyc();
    bus.if_ready = 1'b0;
    cyc(); cyc();
    sample(); chk("full head pc", bus.if_pc, 4);
    cyc();
    reset = 1'b1;
    sb.delete();
    cyc();
    reset = 1'b0; bus.if_ready = 1'b1;
    push_range(0, 24);
    sample(); chk("post-rst valid", XLEN'(bus.if_valid), 0);
    wait_halt(30);

    // from halt: back-to-back redirects, the second (0x8) wins
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    push_range(8, 24);
    sample(); chk("halt held", XLEN'(bus.halted), 1);
    cyc();
    bus.redirect_pc = 32'h8;
    sample(); chk("halt cleared", XLEN'(bus.halted), 0);
    cyc();
    bus.redirect_valid = 1'b0;
    sample(); chk("b2b N+2 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample(); chk("b2b N+3 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample();
    chk("b2b N+4 valid", XLEN'(bus.if_valid), 1);
    chk("b2b N+4 pc", bus.if_pc, 8);
    wait_halt(30);

    // redirect + pop in the same cycle, queue holds pc 4 and 8;
    // low address bits of redirect_pc are ignored (0x16 -> 0x14)
    do_reset();
    bus.if_ready = 1'b1;
    sb.push_back(0); sb.push_back(4);
    push_range(20, 24);
    cyc(); cyc(); cyc();
    bus.if_ready = 1'b0;
    cyc(); cyc();
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h16;
    sample(); chk("rp head pc", bus.if_pc, 4);
    cyc();
    bus.redirect_valid = 1'b0;
    sample(); chk("rp N+1 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample(); chk("rp N+2 valid", XLEN'(bus.if_valid), 0);
    cyc(); sample();
    chk("rp N+3 valid", XLEN'(bus.if_valid), 1);
    chk("rp N+3 pc", bus.if_pc, 32'h14);
    wait_halt(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
